// File: rtl/bitty_trace_buffer_if.sv
// rtl/bitty_trace_buffer_if.sv - capture/trigger/readback signal bundle for the trace buffer
interface bitty_trace_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int AW = $clog2(DEPTH);

    logic              ena;
    logic [DATA_W-1:0] sample_in;
    logic              arm;
    logic [AW-1:0]     pretrig;
    logic [DATA_W-1:0] trig_value;
    logic [DATA_W-1:0] trig_mask;
    logic              rd_req;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              triggered;
    logic              done;
    logic [2:0]        state;

    modport master (
        output ena, sample_in, arm, pretrig, trig_value, trig_mask, rd_req,
        input  rd_data, rd_valid, triggered, done, state
    );

    modport slave (
        input  ena, sample_in, arm, pretrig, trig_value, trig_mask, rd_req,
        output rd_data, rd_valid, triggered, done, state
    );
endinterface

// File: rtl/bitty_trace_buffer.sv
// rtl/bitty_trace_buffer.sv - circular trace buffer with masked trigger and pre-trigger window
module bitty_trace_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bitty_trace_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, pre_cnt_q, post_cnt_q, trig_ptr_q, rd_ptr_q, rd_idx_q, pre_q;
    logic [DATA_W-1:0] value_q, mask_q, rd_data_q;
    logic              triggered_q, done_q, rd_valid_q;

    logic capturing, wr_en, hit;
    assign capturing = (state_q == S_FILL) || (state_q == S_WAIT) || (state_q == S_POST);
    assign wr_en     = capturing && bus.ena && !bus.arm;
    assign hit       = ((bus.sample_in ^ value_q) & mask_q) == '0;

    // Sample storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= bus.sample_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            rd_idx_q    <= '0;
            pre_q       <= '0;
            value_q     <= '0;
            mask_q      <= '0;
            rd_data_q   <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (bus.arm) begin
                pre_q       <= bus.pretrig;
                value_q     <= bus.trig_value;
                mask_q      <= bus.trig_mask;
                wr_ptr_q    <= '0;
                pre_cnt_q   <= '0;
                rd_idx_q    <= '0;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
                state_q     <= (bus.pretrig == '0) ? S_WAIT : S_FILL;
            end else begin
                if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
                case (state_q)
                    S_FILL: if (bus.ena) begin
                        pre_cnt_q <= pre_cnt_q + AW'(1);
                        if (pre_cnt_q + AW'(1) == pre_q) state_q <= S_WAIT;
                    end
                    S_WAIT: if (bus.ena && hit) begin
                        trig_ptr_q  <= wr_ptr_q;
                        triggered_q <= 1'b1;
                        post_cnt_q  <= LAST - pre_q;
                        // Full pre-trigger window means the trigger sample is the last one.
                        if (pre_q == LAST) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            rd_ptr_q <= wr_ptr_q - pre_q;
                        end else begin
                            state_q <= S_POST;
                        end
                    end
                    S_POST: if (bus.ena) begin
                        post_cnt_q <= post_cnt_q - AW'(1);
                        if (post_cnt_q == AW'(1)) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            rd_ptr_q <= trig_ptr_q - pre_q;
                        end
                    end
                    S_DONE: if (bus.rd_req) begin
                        rd_data_q  <= mem[rd_ptr_q];
                        rd_valid_q <= 1'b1;
                        rd_ptr_q   <= rd_ptr_q + AW'(1);
                        rd_idx_q   <= rd_idx_q + AW'(1);
                        if (rd_idx_q == LAST) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.triggered = triggered_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;
endmodule

// File: doc/bitty_trace_buffer.md
# bitty_trace_buffer

On-chip logic-analyser block for the Bitty TinyTapeout design. It samples a parametrised-width bus, typically `uo_out` of `tt_um_bitty`, into a circular buffer every enabled cycle. A masked-compare trigger freezes the capture window, with a programmable number of pre-trigger samples kept ahead of the trigger sample. The captured window is then read back one word per request, so silicon can be debugged through spare pins the way the cocotb bench observes the core in simulation.

## Interface
Parameters:
- `DATA_W`, 8: width of sampled bus, trigger value/mask and read data.
- `DEPTH`, 16: buffer depth in samples; power of two, ≥ 4. `AW = $clog2(DEPTH)`.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `ena`  in  1: sample enable; low freezes capture, counters and FSM.
- `sample_in`  in  DATA_W: bus being traced.
- `arm`  in  1: one-cycle pulse; starts a new capture from any state.
- `pretrig`  in  AW: number of pre-trigger samples kept (0..DEPTH-1); latched on `arm`.
- `trig_value`  in  DATA_W: trigger compare value; latched on `arm`.
- `trig_mask`  in  DATA_W: trigger compare mask (1 = bit compared); latched on `arm`.
- `rd_req`  in  1: read request; honoured only in DONE.
- `rd_data`  out  DATA_W: read-back word.
- `rd_valid`  out  1: `rd_data` valid this cycle (one-cycle pulse).
- `triggered`  out  1: trigger seen in current capture.
- `done`  out  1: full window captured, readback available.
- `state`  out  3: FSM state code.

## Operation
- FSM states and `state` codes: IDLE=0, FILL=1, WAIT=2, POST=3, DONE=4.
- Reset: all outputs 0; state IDLE; write pointer, counters, latched config and read index 0. Buffer contents are not reset.
- `arm` in any state:
  - Latch `pretrig`, `trig_value` and `trig_mask`.
  - Clear `wr_ptr`, `pre_cnt`, `triggered` and `done`.
  - Go to FILL, or to WAIT if `pretrig`=0.
  - `arm` has priority over every other event in the same cycle, including `ena`=0.
  - The sample on the `arm` cycle itself is not written.
- Writes:
  - In FILL, WAIT and POST with `ena`=1, write `mem[wr_ptr] <= sample_in` and `wr_ptr <= wr_ptr+1` (mod DEPTH).
- FILL:
  - The trigger is ignored.
  - `pre_cnt` increments per write.
  - When the write that makes `pre_cnt`=PRE occurs, go to WAIT.
- WAIT:
  - Writes continue circularly, overwriting the oldest samples.
  - Trigger condition: `(sample_in & mask) == (value & mask)` with `ena`=1. The trigger sample is written.
  - On trigger, record `trig_ptr` = slot written, set `triggered`, and load `post_cnt` = DEPTH-1-PRE.
  - If `post_cnt` would be 0, go directly to DONE; otherwise go to POST.
  - With mask=0, the first WAIT sample triggers.
- POST:
  - Writes decrement `post_cnt`.
  - The write that brings it to 0 moves the FSM to DONE.
- Captured window: DEPTH samples in total, made up of PRE pre-trigger samples, the trigger sample, and DEPTH-1-PRE post-trigger samples.
- DONE:
  - `done`=1 and there are no writes.
  - Read pointer starts at `trig_ptr - PRE` (mod DEPTH), which is the oldest sample in the window. The read index starts at 0.
  - Each `rd_req` registers `rd_data <= mem[rd_ptr]`, increments `rd_ptr` and the read index, and pulses `rd_valid` the next cycle.
  - The DEPTH-th request returns the FSM to IDLE, clearing `done`. `triggered` holds until the next `arm`.
  - `rd_req` outside DONE is ignored and `rd_valid` stays 0.
- `ena`=0 in FILL, WAIT or POST: no write, no trigger evaluation, and all state holds. `ena` does not gate reads.

## Timing
- The write and the trigger are evaluated on the same edge. `triggered` and `state` change on the edge after the trigger sample is presented.
- `done` rises on the edge on which the last post-trigger sample is written.
- Read latency is 1 cycle from `rd_req` to `rd_valid`/`rd_data`.
- Back-to-back `rd_req` every cycle is allowed, giving one word per cycle.
- On the final read, the state becomes IDLE on the same edge that `rd_valid` rises.
- Asynchronous reset mid-capture or mid-readback drops immediately to IDLE, with `done`=`triggered`=`rd_valid`=0.
- Write pointer wrap DEPTH-1 → 0 is seamless; no sample is lost or duplicated.

## Test plan
- **Basic window.** DEPTH=16, `pretrig`=4, value=0x20, mask=0xFF. Drive `sample_in` as an incrementing count from 0x00, one per cycle, after `arm`. Required: `triggered` rises the cycle after 0x20 is presented, `done` rises after 0x2B is written, and 16 reads return 0x1C..0x2B in order, then `state`=0.
- **Zero pre-trigger.** `pretrig`=0, value=0x05. Required: `arm` goes straight to WAIT (`state`=2), and readback is 0x05..0x14.
- **Maximum pre-trigger with pointer wrap.** `pretrig`=15, trigger at 0x40. Required: WAIT → DONE directly, and readback is 0x31..0x40.
- **Mask and ena gating.** mask=0xF0, value=0x3A, with `ena` low on alternate cycles. Required: trigger on the first written sample 0x30..0x3F, and no samples are written on cycles where `ena`=0.
- **Re-arm and ignored reads.** `arm` in POST restarts with `triggered`=0 and `state`=1. `rd_req` in WAIT gives no `rd_valid`. Async reset during readback gives all outputs 0 at once.
- **Back-to-back reads.** `rd_req` held for 16 cycles in DONE. Required: 16 consecutive `rd_valid` pulses, correct order, and `done`=0 afterwards.
